xmem_master: RTL

XMEM_MASTER -- requirements
Module: xmem_master

---
 rtl/xmem_master.sv | 101 ++++++++++
 1 files changed

// File: rtl/xmem_master.sv
// xmem_master: multiplexed address/data external bus master with ALE latch and wait-stated strobes.
// All bus outputs are registered from the next-state decode so they change cleanly on clk edges.
module xmem_master #(
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    inout  wire  [7:0]  ad,
    output logic [7:0]  a,
    output logic        ale,
    output logic        nRD,
    output logic        nWR
);
    typedef enum logic [2:0] {IDLE, ADDR, LATCH, STROBE, HOLD} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        we_r, we_c, cap;
    logic [15:0] addr_r, addr_c;
    logic [7:0]  wdata_r, wdata_c;
    logic        ad_oe, ad_oe_n, ale_n, nrd_n, nwr_n, ack_n, busy_n, addr_ph;
    logic [7:0]  ad_q, ad_n, a_n;

    assign ad = ad_oe ? ad_q : 8'bz;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 8'h00;
            rdata   <= 8'h00;
        end else begin
            state   <= state_n;
            we_r    <= we_c;
            addr_r  <= addr_c;
            wdata_r <= wdata_c;
            cnt     <= state == LATCH ? 4'(WAIT) : (state == STROBE && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            if (state == STROBE && cnt == 4'd0 && !we_r)
                rdata <= ad;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = req ? ADDR : IDLE;
            ADDR:    state_n = LATCH;
            LATCH:   state_n = STROBE;
            STROBE:  state_n = cnt == 4'd0 ? HOLD : STROBE;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Capture muxes let the ADDR-cycle outputs see the request being accepted on this edge.
    always_comb begin
        cap     = state == IDLE && req;
        we_c    = cap ? we : we_r;
        addr_c  = cap ? addr : addr_r;
        wdata_c = cap ? wdata : wdata_r;
        addr_ph = state_n == ADDR || state_n == LATCH;
        busy_n  = state_n != IDLE;
        ale_n   = state_n == ADDR;
        ack_n   = state_n == HOLD;
        nrd_n   = !(state_n == STROBE && !we_c);
        nwr_n   = !(state_n == STROBE && we_c);
        ad_oe_n = addr_ph || ((state_n == STROBE || state_n == HOLD) && we_c);
        ad_n    = addr_ph ? addr_c[7:0] : wdata_c;
        a_n     = busy_n ? addr_c[15:8] : 8'h00;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy  <= 1'b0;
            ack   <= 1'b0;
            ale   <= 1'b0;
            nRD   <= 1'b1;
            nWR   <= 1'b1;
            ad_oe <= 1'b0;
            ad_q  <= 8'h00;
            a     <= 8'h00;
        end else begin
            busy  <= busy_n;
            ack   <= ack_n;
            ale   <= ale_n;
            nRD   <= nrd_n;
            nWR   <= nwr_n;
            ad_oe <= ad_oe_n;
            ad_q  <= ad_n;
            a     <= a_n;
        end
    end
endmodule
